// File: rtl/servo_pulse_decoder.sv
// Servo PWM high-time decoder: measures pulse width and maps it back to an 8-bit angle code.
// Optional macro SERVO_DEC_GLITCH_FILTER_EN adds a 4-sample stability filter after the synchronizer.
module servo_pulse_decoder #(
    parameter int unsigned OFFSET        = 165,
    parameter int unsigned SHIFT         = 8,
    parameter int unsigned MARGIN        = 16,
    parameter int unsigned FRAME_TIMEOUT = 2097152
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pulse_in,
    output logic [7:0] angulo,
    output logic       angulo_valid,
    output logic       range_err,
    output logic       signal_ok
);

    localparam int unsigned WIDTH_W  = 20;
    localparam int unsigned WIDTH_RW = WIDTH_W + 1;
    localparam int unsigned FRAME_W  = 22;
    localparam int unsigned Q_W      = 13;
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam int unsigned FILL     = 5;
`else
    localparam int unsigned FILL     = 2;
`endif

    localparam logic [WIDTH_W-1:0]  WIDTH_SAT = '1;
    localparam logic [WIDTH_W-1:0]  WIDTH_MAX = WIDTH_W'((OFFSET + 256 + MARGIN) << SHIFT);
    localparam logic [WIDTH_RW-1:0] ROUND     = WIDTH_RW'(32'd1 << (SHIFT - 1));
    localparam logic [FRAME_W-1:0]  FRAME_LIM = FRAME_W'(FRAME_TIMEOUT);
    localparam logic [Q_W-1:0]      Q_MIN     = Q_W'(OFFSET - MARGIN);
    localparam logic [Q_W-1:0]      Q_MAX     = Q_W'(OFFSET + 255 + MARGIN);
    localparam logic [Q_W-1:0]      Q_OFF     = Q_W'(OFFSET);
    localparam logic [Q_W-1:0]      Q_TOP     = Q_W'(OFFSET + 255);

    typedef enum logic [1:0] {
        ST_ARM,
        ST_LOW,
        ST_HIGH,
        ST_STUCK
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           sync_q;
    logic                 lvl_q;
    logic                 lvl_c;
    logic                 rise_c, fall_c;
    logic [2:0]           fill_q, fill_d;
    logic [WIDTH_W-1:0]   width_q, width_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic                 timeout_c;
    logic                 dec_pend_q, dec_pend_d;
    logic [WIDTH_W-1:0]   dec_width_q, dec_width_d;
    logic                 long_err_c;
    logic [WIDTH_RW-1:0]  sum_c;
    logic [Q_W-1:0]       q_c;
    logic                 in_range_c;
    logic [7:0]           ang_c;
    logic [7:0]           angulo_q, angulo_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 ok_q, ok_d;

`ifdef SERVO_DEC_GLITCH_FILTER_EN
    logic [2:0] hist_q;

    // Level only moves after four consecutive identical synchronized samples
    always_comb begin
        lvl_c = lvl_q;
        if ({sync_q[1], hist_q} == 4'b1111) begin
            lvl_c = 1'b1;
        end else if ({sync_q[1], hist_q} == 4'b0000) begin
            lvl_c = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end
`else
    assign lvl_c = sync_q[1];
`endif

    assign rise_c    = lvl_c & ~lvl_q;
    assign fall_c    = ~lvl_c & lvl_q;
    assign timeout_c = (frame_q == FRAME_LIM) && !rise_c;

    // Counters; the rising-edge cycle is itself the first high cycle, so width equals high time
    always_comb begin
        fill_d  = (fill_q == 3'(FILL)) ? fill_q : fill_q + 3'd1;
        width_d = width_q;
        if (rise_c) begin
            width_d = WIDTH_W'(1);
        end else if (lvl_c && width_q != WIDTH_SAT) begin
            width_d = width_q + WIDTH_W'(1);
        end
        frame_d = frame_q;
        if (rise_c) begin
            frame_d = '0;
        end else if (frame_q != FRAME_LIM) begin
            frame_d = frame_q + FRAME_W'(1);
        end
    end

    // Pulse FSM; ARM waits until the synchronizer holds real samples before trusting a low
    always_comb begin
        state_d     = state_q;
        dec_pend_d  = 1'b0;
        dec_width_d = dec_width_q;
        long_err_c  = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (fill_q == 3'(FILL) && !lvl_c) begin
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (rise_c) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (fall_c) begin
                    dec_pend_d  = 1'b1;
                    dec_width_d = width_q;
                    state_d     = ST_LOW;
                end else if (width_q >= WIDTH_MAX) begin
                    long_err_c = 1'b1;
                    state_d    = ST_STUCK;
                end
            end
            ST_STUCK: begin
                if (fall_c) begin
                    state_d = ST_LOW;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // Decode stage: round to nearest quantum, range check, clamp
    always_comb begin
        sum_c      = WIDTH_RW'(dec_width_q) + ROUND;
        q_c        = Q_W'(sum_c >> SHIFT);
        in_range_c = (q_c >= Q_MIN) && (q_c <= Q_MAX);
        if (q_c < Q_OFF) begin
            ang_c = 8'd0;
        end else if (q_c > Q_TOP) begin
            ang_c = 8'd255;
        end else begin
            ang_c = 8'(q_c - Q_OFF);
        end

        angulo_d = angulo_q;
        valid_d  = dec_pend_q && in_range_c;
        err_d    = long_err_c || (dec_pend_q && !in_range_c);
        ok_d     = ok_q;
        if (valid_d) begin
            angulo_d = ang_c;
            ok_d     = 1'b1;
        end else if (timeout_c) begin
            ok_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_ARM;
            sync_q      <= '0;
            lvl_q       <= 1'b0;
            fill_q      <= '0;
            width_q     <= '0;
            frame_q     <= '0;
            dec_pend_q  <= 1'b0;
            dec_width_q <= '0;
            angulo_q    <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[0], pulse_in};
            lvl_q       <= lvl_c;
            fill_q      <= fill_d;
            width_q     <= width_d;
            frame_q     <= frame_d;
            dec_pend_q  <= dec_pend_d;
            dec_width_q <= dec_width_d;
            angulo_q    <= angulo_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            ok_q        <= ok_d;
        end
    end

    assign angulo       = angulo_q;
    assign angulo_valid = valid_q;
    assign range_err    = err_q;
    assign signal_ok    = ok_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder with a scaled quantum (SHIFT=2) and short frame timeout.
module tb_servo_pulse_decoder;

    localparam int OFFSET  = 165;
    localparam int SHIFT   = 2;
    localparam int MARGIN  = 16;
    localparam int TIMEOUT = 3000;
    localparam int Q       = 1 << SHIFT;
    localparam int T       = (OFFSET + 256 + MARGIN) * Q;
`ifdef SERVO_DEC_GLITCH_FILTER_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       pulse_in;
    logic [7:0] angulo;
    logic       angulo_valid;
    logic       range_err;
    logic       signal_ok;

    servo_pulse_decoder #(
        .OFFSET(OFFSET), .SHIFT(SHIFT), .MARGIN(MARGIN), .FRAME_TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .pulse_in(pulse_in), .angulo(angulo),
        .angulo_valid(angulo_valid), .range_err(range_err), .signal_ok(signal_ok)
    );

    always #5 clock = ~clock;

    typedef struct {
        int kind;   // 1 = angulo_valid, 2 = range_err
        int cyc;
        int ang;
    } ev_t;

    typedef struct {
        int high;
        int kind;
        int ang;
    } vec_t;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  overlap = 0;
    int  model_ang = 0;
    int  model_ok = 0;
    ev_t got_q[$];
    ev_t exp_q[$];
    vec_t vecs[11];

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (angulo_valid) got_q.push_back('{kind: 1, cyc: cyc, ang: int'(angulo)});
        if (range_err)    got_q.push_back('{kind: 2, cyc: cyc, ang: 0});
        if (angulo_valid && range_err) overlap++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one high pulse then a low gap; returns the first high sampling edge and edge N
    task automatic drive(input int h, input int gap, output int r, output int n);
        r = cyc + 1;
        pulse_in = 1'b1;
        step(h);
        n = cyc + 1;
        pulse_in = 1'b0;
        step(gap);
    endtask

    // Reference: round width to quanta, reject outside the margin window, clamp into 0..255
    task automatic model_pulse(input int h, input int n);
        int qv, a;
        qv = (h + Q / 2) / Q;
        if (qv < OFFSET - MARGIN || qv > OFFSET + 255 + MARGIN) begin
            exp_q.push_back('{kind: 2, cyc: n + LAT, ang: 0});
        end else begin
            a = qv - OFFSET;
            if (a < 0) a = 0;
            if (a > 255) a = 255;
            model_ang = a;
            model_ok  = 1;
            exp_q.push_back('{kind: 1, cyc: n + LAT, ang: a});
        end
    endtask

    task automatic check_events(input string name);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s event count: got %0d expected %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (got_q[i].kind != exp_q[i].kind || got_q[i].cyc != exp_q[i].cyc ||
                    got_q[i].ang != exp_q[i].ang) begin
                    failures++;
                    $display("FAIL %s event %0d: got kind=%0d cyc=%0d ang=%0d expected kind=%0d cyc=%0d ang=%0d",
                             name, i, got_q[i].kind, got_q[i].cyc, got_q[i].ang,
                             exp_q[i].kind, exp_q[i].cyc, exp_q[i].ang);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
        chk({name, " angulo"}, int'(angulo), model_ang);
        chk({name, " signal_ok"}, int'(signal_ok), model_ok);
    endtask

    task automatic check_zero(input string name);
        chk({name, " angulo"}, int'(angulo), 0);
        chk({name, " angulo_valid"}, int'(angulo_valid), 0);
        chk({name, " range_err"}, int'(range_err), 0);
        chk({name, " signal_ok"}, int'(signal_ok), 0);
    endtask

    initial begin
        int r, n, n1, h, gap;

        // {high cycles, expected kind, expected angle} with quantum 4
        vecs[0]  = '{high: 1060, kind: 1, ang: 100};
        vecs[1]  = '{high: 659,  kind: 1, ang: 0};
        vecs[2]  = '{high: 1681, kind: 1, ang: 255};
        vecs[3]  = '{high: 620,  kind: 1, ang: 0};
        vecs[4]  = '{high: 560,  kind: 2, ang: 0};
        vecs[5]  = '{high: 596,  kind: 1, ang: 0};
        vecs[6]  = '{high: 593,  kind: 2, ang: 0};
        vecs[7]  = '{high: 1744, kind: 1, ang: 255};
        vecs[8]  = '{high: 1746, kind: 2, ang: 0};
        vecs[9]  = '{high: 1062, kind: 1, ang: 101};
        vecs[10] = '{high: 1061, kind: 1, ang: 100};

        reset = 1'b1;
        pulse_in = 1'b0;
        step(3);
        check_zero("in_reset");
        reset = 1'b0;
        step(10);
        check_zero("after_reset");

        foreach (vecs[i]) begin
            drive(vecs[i].high, 20, r, n);
            exp_q.push_back('{kind: vecs[i].kind, cyc: n + LAT, ang: vecs[i].ang});
            if (vecs[i].kind == 1) begin
                model_ang = vecs[i].ang;
                model_ok  = 1;
            end
            check_events($sformatf("vec%0d", i));
        end

        // Input stuck high well past the threshold, then a normal pulse
        r = cyc + 1;
        pulse_in = 1'b1;
        step(2500);
        pulse_in = 1'b0;
        step(20);
        exp_q.push_back('{kind: 2, cyc: r + T + LAT - 1, ang: 0});
        check_events("stuck");
        drive(1060, 20, r, n);
        model_pulse(1060, n);
        check_events("after_stuck");

        // Loss of signal: signal_ok drops TIMEOUT+1 cycles after the rise is seen
        drive(1060, 20, r, n);
        model_pulse(1060, n);
        check_events("pre_timeout");
        step(r + TIMEOUT + LAT - 1 - cyc);
        chk("timeout_edge_minus1 signal_ok", int'(signal_ok), 1);
        step(1);
        chk("timeout_edge signal_ok", int'(signal_ok), 0);
        model_ok = 0;
        step(20);
        check_events("timeout_hold");
        drive(1681, 20, r, n);
        model_pulse(1681, n);
        check_events("after_timeout");

        // Reset in the middle of a pulse discards that pulse
        pulse_in = 1'b1;
        step(500);
        reset = 1'b1;
        step(2);
        check_zero("midpulse_reset");
        reset = 1'b0;
        step(560);
        pulse_in = 1'b0;
        step(20);
        model_ang = 0;
        model_ok  = 0;
        check_events("partial_pulse");
        drive(1060, 20, r, n);
        model_pulse(1060, n);
        check_events("after_midreset");

        // Two-cycle low glitch inside a 1060-cycle pulse
        pulse_in = 1'b1;
        step(500);
        n1 = cyc + 1;
        pulse_in = 1'b0;
        step(2);
        pulse_in = 1'b1;
        step(558);
        n = cyc + 1;
        pulse_in = 1'b0;
        step(20);
`ifdef SERVO_DEC_GLITCH_FILTER_EN
        exp_q.push_back('{kind: 1, cyc: n + LAT, ang: 100});
        model_ang = 100;
        model_ok  = 1;
`else
        exp_q.push_back('{kind: 2, cyc: n1 + LAT, ang: 0});
        exp_q.push_back('{kind: 2, cyc: n + LAT, ang: 0});
`endif
        check_events("glitch");

        // Random widths across accept/clamp/reject regions
        for (int i = 0; i < 25; i++) begin
            h   = int'($urandom_range(1747, 500));
            gap = int'($urandom_range(200, 10));
            drive(h, gap, r, n);
            model_pulse(h, n);
            check_events($sformatf("rand%0d_w%0d", i, h));
        end

        chk("valid_err_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
